// File: rtl/mux_pipe_n_pkg.sv
// Shared definitions for the pipelined N-way select.
// Optional feature macro: MUX_SEL_ERR_EN (per-beat out-of-range select flag).
package mux_pipe_n_pkg;

    // Handshake occupancy, encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        HS_EMPTY = 2'b00,
        HS_ONE   = 2'b10,
        HS_FULL  = 2'b11
    } hs_state_e;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// Slice source k out of a flattened bus of w-bit sources.
`ifndef MUX_SRC
`define MUX_SRC(bus, k, w) bus[(k)*(w) +: (w)]
`endif

// File: rtl/mux_sel_n.sv
// Combinational N-way select; codes >= N clamp to the last source.
// With MUX_SEL_ERR_EN an out-of-range flag is also produced.
module mux_sel_n #(
    parameter int unsigned W  = 32,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic [N*W-1:0] in_data_i,
    input  logic [SW-1:0]  sel_i,
    output logic [W-1:0]   data_c
`ifdef MUX_SEL_ERR_EN
    ,
    output logic           oob_c
`endif
);

    // Default to the last source so every unmatched code clamps to it.
    always_comb begin
        data_c = `MUX_SRC(in_data_i, N - 1, W);
        for (int unsigned k = 0; k < N - 1; k++) begin
            if (sel_i == SW'(k)) begin
                data_c = `MUX_SRC(in_data_i, k, W);
            end
        end
    end

`ifdef MUX_SEL_ERR_EN
    // Flag any code that does not name a real source.
    always_comb begin
        oob_c = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel_i == SW'(k)) begin
                oob_c = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined N-way W-bit select with a 2-entry skid buffer and valid/ready handshake.
// in_ready depends only on registered state and rst, never on out_ready.
// Optional feature macro: MUX_SEL_ERR_EN adds the sel_err output.
module mux_pipe_n
    import mux_pipe_n_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic           sel_err
`endif
);

    // Reject configurations whose select cannot address every source.
    if ((64'd1 << SW) < 64'(N)) begin : g_sw_check
        $error("mux_pipe_n: SW is too narrow for N sources");
    end

    hs_state_e    state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic [W-1:0] sel_data_c;
    logic         accept_c, drain_c;
    logic         ld_main_in_c, ld_main_skid_c, ld_skid_c;

`ifdef MUX_SEL_ERR_EN
    localparam bit ERR_TIED = is_pow2(N);
    logic oob_c;
    logic err_in_c;
    logic main_err_q, main_err_d;
    logic skid_err_q, skid_err_d;
`endif

    // Input-side select, evaluated at acceptance.
    mux_sel_n #(
        .W  (W),
        .N  (N),
        .SW (SW)
    ) u_sel (
        .in_data_i (in_data),
        .sel_i     (in_sel),
        .data_c    (sel_data_c)
`ifdef MUX_SEL_ERR_EN
        ,
        .oob_c     (oob_c)
`endif
    );

    // Handshake status straight from the occupancy register.
    assign in_ready  = (state_q != HS_FULL) & ~rst;
    assign out_valid = (state_q != HS_EMPTY);
    assign out_data  = main_q;
    assign accept_c  = in_valid & in_ready;
    assign drain_c   = out_valid & out_ready;

    // Occupancy next-state and storage load strobes.
    always_comb begin
        state_d        = state_q;
        ld_main_in_c   = 1'b0;
        ld_main_skid_c = 1'b0;
        ld_skid_c      = 1'b0;
        case (state_q)
            HS_EMPTY: begin
                if (accept_c) begin
                    ld_main_in_c = 1'b1;
                    state_d      = HS_ONE;
                end
            end
            HS_ONE: begin
                if (accept_c && drain_c) begin
                    ld_main_in_c = 1'b1;
                end else if (accept_c) begin
                    ld_skid_c = 1'b1;
                    state_d   = HS_FULL;
                end else if (drain_c) begin
                    state_d = HS_EMPTY;
                end
            end
            HS_FULL: begin
                if (drain_c) begin
                    ld_main_skid_c = 1'b1;
                    state_d        = HS_ONE;
                end
            end
            default: begin
                state_d = HS_EMPTY;
            end
        endcase
    end

    // Data storage next values; main holds still while stalled.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (ld_main_in_c) begin
            main_d = sel_data_c;
        end else if (ld_main_skid_c) begin
            main_d = skid_q;
        end
        if (ld_skid_c) begin
            skid_d = sel_data_c;
        end
    end

    // Occupancy and data registers; reset discards any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef MUX_SEL_ERR_EN
    assign err_in_c = ERR_TIED ? 1'b0 : oob_c;

    // Error flag travels with its beat and clears when main empties.
    always_comb begin
        main_err_d = main_err_q;
        skid_err_d = skid_err_q;
        if (ld_main_in_c) begin
            main_err_d = err_in_c;
        end else if (ld_main_skid_c) begin
            main_err_d = skid_err_q;
        end else if (state_d == HS_EMPTY) begin
            main_err_d = 1'b0;
        end
        if (ld_skid_c) begin
            skid_err_d = err_in_c;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_err_q <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            main_err_q <= main_err_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign sel_err = main_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Self-checking bench for mux_pipe_n: three configurations (N=3/W=32, N=2/W=1, N=5/W=8).
module tb_mux_pipe_n;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: N=3, W=32
    logic [95:0] a_data  = '0;
    logic [1:0]  a_sel   = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_odata;
    logic        a_ovalid;
    logic        a_oready = 1'b0;
    // Instance B: N=2, W=1
    logic [1:0]  b_data  = '0;
    logic [0:0]  b_sel   = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [0:0]  b_odata;
    logic        b_ovalid;
    logic        b_oready = 1'b0;
    // Instance C: N=5, W=8, SW=3
    logic [39:0] c_data  = '0;
    logic [2:0]  c_sel   = '0;
    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [7:0]  c_odata;
    logic        c_ovalid;
    logic        c_oready = 1'b0;
`ifdef MUX_SEL_ERR_EN
    logic a_err, b_err, c_err;
`endif

    mux_pipe_n #(.W(32), .N(3), .SW(2)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(a_err)
`endif
    );
    mux_pipe_n #(.W(1), .N(2), .SW(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(b_err)
`endif
    );
    mux_pipe_n #(.W(8), .N(5), .SW(3)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
        .in_ready(c_ready), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(c_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic [2:0] sel, input logic v, input logic ordy);
        case (which)
            0: begin a_sel = sel[1:0]; a_valid = v; a_oready = ordy; end
            1: begin b_sel = sel[0:0]; b_valid = v; b_oready = ordy; end
            default: begin c_sel = sel; c_valid = v; c_oready = ordy; end
        endcase
    endtask

    task automatic peek(input int which, output logic [31:0] d, output logic v, output logic r);
        case (which)
            0: begin d = a_odata; v = a_ovalid; r = a_ready; end
            1: begin d = 32'(b_odata); v = b_ovalid; r = b_ready; end
            default: begin d = 32'(c_odata); v = c_ovalid; r = c_ready; end
        endcase
    endtask

`ifdef MUX_SEL_ERR_EN
    function automatic logic peek_err(input int which);
        case (which)
            0: return a_err;
            1: return b_err;
            default: return c_err;
        endcase
    endfunction
`endif

    // Stream a vector table with out_ready=1: each beat appears one cycle after accept, no bubbles.
    task automatic run_table(input int which, input string tag, input vec_t tbl[$]);
        logic [31:0] d;
        logic v, r;
        @(negedge clk);
        drive(which, tbl[0].sel, 1'b1, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            peek(which, d, v, r);
            check($sformatf("%s_valid[%0d]", tag, i), 32'(v), 32'd1);
            check($sformatf("%s_ready[%0d]", tag, i), 32'(r), 32'd1);
            check($sformatf("%s_data[%0d]", tag, i), d, tbl[i].exp);
`ifdef MUX_SEL_ERR_EN
            check($sformatf("%s_err[%0d]", tag, i), 32'(peek_err(which)), 32'(tbl[i].err));
`endif
            if (i + 1 < tbl.size()) drive(which, tbl[i + 1].sel, 1'b1, 1'b1);
            else drive(which, 3'd0, 1'b0, 1'b1);
        end
        @(negedge clk);
        peek(which, d, v, r);
        check({tag, "_drained_valid"}, 32'(v), 32'd0);
`ifdef MUX_SEL_ERR_EN
        check({tag, "_drained_err"}, 32'(peek_err(which)), 32'd0);
`endif
    endtask

    function automatic int clamp3(input int sel);
        return (sel >= 3) ? 2 : sel;
    endfunction

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t1[$];
        vec_t t5[$];
        vec_t t6[$];
        int          seq, sent, got, cyc;
        logic        acc, prev_stall;
        logic [31:0] prev_data;
        logic [31:0] exp_q[$];
        logic [31:0] expv;

        t1 = '{'{3'd0, 32'h11111111, 1'b0}, '{3'd1, 32'h22222222, 1'b0},
               '{3'd2, 32'h33333333, 1'b0}, '{3'd3, 32'h33333333, 1'b1}};
        t6 = '{'{3'd0, 32'd0, 1'b0}, '{3'd1, 32'd1, 1'b0},
               '{3'd0, 32'd0, 1'b0}, '{3'd1, 32'd1, 1'b0}};
        for (int s = 0; s < 8; s++) begin
            vec_t e;
            e.sel = 3'(s);
            e.exp = 32'h000000A0 + 32'((s >= 5) ? 4 : s);
            e.err = (s >= 5);
            t5.push_back(e);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_valid", 32'(a_ovalid), 32'd0);
        check("rst_a_data", a_odata, 32'd0);
        check("rst_b_valid", 32'(b_ovalid), 32'd0);
        check("rst_c_data", 32'(c_odata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd1);
        check("post_rst_c_ready", 32'(c_ready), 32'd1);

        // Clamp rule and streaming on each configuration
        a_data = {32'h33333333, 32'h22222222, 32'h11111111};
        run_table(0, "t1_n3", t1);
        b_data = 2'b10;
        run_table(1, "t6_n2", t6);
        c_data = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        run_table(2, "t5_n5", t5);

        // Back-pressure: A then B with out_ready=0
        @(negedge clk);
        a_oready = 1'b0; a_valid = 1'b1; a_sel = 2'd0; a_data[31:0] = 32'hAAAA0001;
        @(negedge clk);
        check("bp_ready_after_a", 32'(a_ready), 32'd1);
        check("bp_valid_a", 32'(a_ovalid), 32'd1);
        check("bp_data_a", a_odata, 32'hAAAA0001);
        a_data[31:0] = 32'hBBBB0002;
        @(negedge clk);
        check("bp_ready_after_b", 32'(a_ready), 32'd0);
        check("bp_data_a_held", a_odata, 32'hAAAA0001);
        a_valid = 1'b0;
        a_data[31:0] = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_data", a_odata, 32'hAAAA0001);
            check("bp_stall_ready", 32'(a_ready), 32'd0);
            check("bp_stall_valid", 32'(a_ovalid), 32'd1);
        end
        a_oready = 1'b1;
        @(negedge clk);
        check("bp_data_b", a_odata, 32'hBBBB0002);
        check("bp_valid_b", 32'(a_ovalid), 32'd1);
        check("bp_ready_resume", 32'(a_ready), 32'd1);
        @(negedge clk);
        check("bp_empty_valid", 32'(a_ovalid), 32'd0);
        check("bp_empty_ready", 32'(a_ready), 32'd1);

        // Random streaming against an ordered queue of expected beats
        seq = 0; sent = 0; got = 0; cyc = 0;
        acc = 1'b0; prev_stall = 1'b0; prev_data = '0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("rnd_stall_valid", 32'(a_ovalid), 32'd1);
                check("rnd_stall_data", a_odata, prev_data);
            end
            if (!a_valid || acc) begin
                a_valid = (sent < 1000) && ($urandom_range(3) != 0);
                a_sel   = 2'($urandom_range(3));
                a_data  = {32'(seq * 4 + 2), 32'(seq * 4 + 1), 32'(seq * 4)};
            end
            a_oready = 1'($urandom_range(1));
            acc = a_valid && a_ready;
            if (acc) begin
                exp_q.push_back(32'(seq * 4 + clamp3(int'(a_sel))));
                seq++;
                sent++;
            end
            if (a_ovalid && a_oready) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
                check($sformatf("rnd_beat[%0d]", got), a_odata, expv);
                got++;
            end
            prev_stall = a_ovalid && !a_oready;
            prev_data  = a_odata;
        end
        check("rnd_beats_received", 32'(got), 32'd1000);
        @(negedge clk);
        a_valid = 1'b0; a_oready = 1'b1;
        repeat (3) @(negedge clk);
        check("rnd_final_empty", 32'(a_ovalid), 32'd0);

        // Reset while FULL discards both stored beats
        a_oready = 1'b0; a_valid = 1'b1; a_sel = 2'd1; a_data[63:32] = 32'hC0C00001;
        @(negedge clk);
        a_data[63:32] = 32'hC0C00002;
        @(negedge clk);
        a_valid = 1'b0;
        check("rf_full_ready", 32'(a_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rf_valid", 32'(a_ovalid), 32'd0);
        check("rf_data", a_odata, 32'd0);
        check("rf_ready", 32'(a_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rf_after_ready", 32'(a_ready), 32'd1);
        a_oready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rf_no_ghost", 32'(a_ovalid), 32'd0);
        end
        a_valid = 1'b1; a_sel = 2'd2; a_data[95:64] = 32'hD00D0003;
        @(negedge clk);
        a_valid = 1'b0;
        check("rf_new_valid", 32'(a_ovalid), 32'd1);
        check("rf_new_data", a_odata, 32'hD00D0003);
        @(negedge clk);
        check("rf_new_drained", 32'(a_ovalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
